// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit password entry buffer.
// Define KEYPAD_BACKSPACE_EN to make key code 11 act as Backspace.
module keypad_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] p0,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic [3:0] p3,
  output logic [2:0] digit_cnt,
  output logic       show_digits,
  output logic       entry_done,
  output logic       entry_err
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0]      DB_LIMIT = 5'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  logic [3:0]       rows_meta, rows_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t     state, state_n;
  logic [1:0] col, col_n;
  logic [1:0] row_lat, row_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] cnt_inc;
  logic       row_low;
  logic       accept;

  // Rows idle high, so the synchronizer resets to "no key"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign row_low = ~rows_sync[row_lat];
  assign cnt_inc = {1'b0, cnt} + 5'd1;
  assign cols    = ~(4'b0001 << col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      row_lat   <= 2'd0;
      cnt       <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row_lat   <= row_n;
      cnt       <= cnt_n;
      key_valid <= accept;
      if (accept) key_code <= {row_lat, col};
    end
  end

  // The column stays frozen from detection until release, so only one key is tracked
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row_lat;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (rows_sync != 4'hF) begin
            state_n = DEBOUNCE;
            cnt_n   = 4'd1;
            if (!rows_sync[0])      row_n = 2'd0;
            else if (!rows_sync[1]) row_n = 2'd1;
            else if (!rows_sync[2]) row_n = 2'd2;
            else                    row_n = 2'd3;
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_low) begin
            if (cnt_inc >= DB_LIMIT) begin
              accept  = 1'b1;
              cnt_n   = 4'd0;
              state_n = HELD;
            end else begin
              cnt_n = cnt_inc[3:0];
            end
          end else begin
            state_n = SCAN;
            col_n   = col + 2'd1;
            cnt_n   = 4'd0;
          end
        end
        HELD: begin
          if (row_low) begin
            cnt_n = 4'd0;
          end else if (cnt_inc >= DB_LIMIT) begin
            state_n = SCAN;
            col_n   = col + 2'd1;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt_inc[3:0];
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // A successful Enter keeps p* for the comparator to sample on entry_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0         <= 4'd0;
      p1         <= 4'd0;
      p2         <= 4'd0;
      p3         <= 4'd0;
      digit_cnt  <= 3'd0;
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (digit_cnt != 3'd4) begin
            p3        <= p2;
            p2        <= p1;
            p1        <= p0;
            p0        <= key_code;
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            4'd10: begin
              p0        <= 4'd0;
              p1        <= 4'd0;
              p2        <= 4'd0;
              p3        <= 4'd0;
              digit_cnt <= 3'd0;
            end
            4'd14: begin
              digit_cnt <= 3'd0;
              if (digit_cnt == 3'd4) begin
                entry_done <= 1'b1;
              end else begin
                entry_err <= 1'b1;
                p0        <= 4'd0;
                p1        <= 4'd0;
                p2        <= 4'd0;
                p3        <= 4'd0;
              end
            end
`ifdef KEYPAD_BACKSPACE_EN
            4'd11: begin
              if (digit_cnt != 3'd0) begin
                p0        <= p1;
                p1        <= p2;
                p2        <= p3;
                p3        <= 4'd0;
                digit_cnt <= digit_cnt - 3'd1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign show_digits = (digit_cnt != 3'd0);

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model presses keys, a password model
// predicts each key_valid response, and a monitor pops and compares them.
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] p0, p1, p2, p3;
  logic [2:0] digit_cnt;
  logic       show_digits, entry_done, entry_err;

  logic       key_down = 1'b0;
  logic [3:0] key      = 4'd0;
  logic       glitch   = 1'b0;

  typedef struct {
    logic [3:0] code;
    int         pval;
    int         cnt;
    bit         done;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   errors      = 0;
  int   pulses_seen = 0;
  int   pushed      = 0;
  int   m_pval      = 0;
  int   m_cnt       = 0;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DB)) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_code(key_code),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .digit_cnt(digit_cnt), .show_digits(show_digits),
    .entry_done(entry_done), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  // Physical keypad: the pressed key shorts its row to its column while that column is driven low
  assign rows = glitch ? 4'b1110 :
                (key_down && !cols[key[1:0]]) ? ~(4'b0001 << key[3:2]) : 4'hF;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_key(input logic [3:0] code, output exp_t e);
    e.done = 1'b0;
    e.err  = 1'b0;
    if (code <= 4'd9) begin
      if (m_cnt < 4) begin
        m_pval = (m_pval * 16 + int'(code)) % 65536;
        m_cnt++;
      end
    end else if (code == 4'd10) begin
      m_pval = 0;
      m_cnt  = 0;
    end else if (code == 4'd14) begin
      if (m_cnt == 4) e.done = 1'b1;
      else begin
        e.err  = 1'b1;
        m_pval = 0;
      end
      m_cnt = 0;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (code == 4'd11) begin
      if (m_cnt > 0) begin
        m_pval = m_pval / 16;
        m_cnt--;
      end
    end
`endif
    e.code = code;
    e.pval = m_pval;
    e.cnt  = m_cnt;
  endtask

  task automatic apply_stimulus(input logic [3:0] code, input int hold_ticks);
    exp_t e;
    int   start, t;
    model_key(code, e);
    exp_q.push_back(e);
    pushed++;
    start    = pulses_seen;
    key      = code;
    key_down = 1'b1;
    t        = 0;
    while (pulses_seen == start && t < 80) begin
      @(negedge clk);
      t++;
    end
    check_output($sformatf("key_valid_arrival_code%0d", code), int'(pulses_seen != start), 1);
    if (pulses_seen == start && exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (hold_ticks * SCAN_DIV + 2) @(negedge clk);
    key_down = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic check_reset_values();
    check_output("rst_cols", int'(cols), 4'b1110);
    check_output("rst_key_valid", int'(key_valid), 0);
    check_output("rst_key_code", int'(key_code), 0);
    check_output("rst_p", int'({p3, p2, p1, p0}), 0);
    check_output("rst_digit_cnt", int'(digit_cnt), 0);
    check_output("rst_show_digits", int'(show_digits), 0);
    check_output("rst_entry_done", int'(entry_done), 0);
    check_output("rst_entry_err", int'(entry_err), 0);
  endtask

  // Monitor: each key_valid pops one prediction; the following cycle shows the buffer update
  initial begin
    exp_t cur;
    bit   post_pending;
    post_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        post_pending = 1'b0;
      end else begin
        if (entry_done && entry_err) check_output("done_err_together", 1, 0);
        if (post_pending) begin
          check_output("p_value", int'({p3, p2, p1, p0}), cur.pval);
          check_output("digit_cnt", int'(digit_cnt), cur.cnt);
          check_output("show_digits", int'(show_digits), int'(cur.cnt != 0));
          check_output("entry_done", int'(entry_done), int'(cur.done));
          check_output("entry_err", int'(entry_err), int'(cur.err));
        end else if (entry_done || entry_err) begin
          check_output("stray_entry_pulse", 1, 0);
        end
        post_pending = 1'b0;
        if (key_valid) begin
          pulses_seen++;
          if (exp_q.size() == 0) begin
            check_output("unexpected_key_valid", int'(key_code), -1);
          end else begin
            cur = exp_q.pop_front();
            check_output("key_code", int'(key_code), int'(cur.code));
            post_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int   seen_mask;
    int   start;
    int   t;
    logic [3:0] code;

    $display("[TB] reset and idle scan");
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check_output($sformatf("idle_cols_k%0d", k), int'(cols), int'(~(4'b0001 << ((k / SCAN_DIV) % 4)) & 4'hF));
    end
    check_output("idle_no_key_valid", pulses_seen, 0);

    $display("[TB] key 6 held");
    apply_stimulus(4'd6, 3);
    check_output("key6_p0", int'(p0), 6);
    check_output("key6_digit_cnt", int'(digit_cnt), 1);
    check_output("key6_show", int'(show_digits), 1);

    $display("[TB] one-tick glitch");
    start  = pulses_seen;
    glitch = 1'b1;
    repeat (SCAN_DIV) @(negedge clk);
    glitch = 1'b0;
    repeat (40) @(negedge clk);
    check_output("glitch_no_key_valid", pulses_seen, start);
    seen_mask = 0;
    repeat (20) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (!cols[c]) seen_mask |= (1 << c);
    end
    check_output("glitch_scan_resumes", seen_mask, 15);

    $display("[TB] full entry and enter");
    apply_stimulus(4'd10, 0);
    apply_stimulus(4'd1, 0);
    apply_stimulus(4'd2, 1);
    apply_stimulus(4'd3, 0);
    apply_stimulus(4'd4, 2);
    apply_stimulus(4'd5, 0);
    apply_stimulus(4'd14, 0);
    check_output("done_p", int'({p3, p2, p1, p0}), 16'h1234);
    check_output("done_digit_cnt", int'(digit_cnt), 0);

    $display("[TB] short entry and enter");
    apply_stimulus(4'd7, 0);
    apply_stimulus(4'd8, 0);
    apply_stimulus(4'd14, 1);
    check_output("err_p", int'({p3, p2, p1, p0}), 0);
    check_output("err_digit_cnt", int'(digit_cnt), 0);

    $display("[TB] backspace key");
    apply_stimulus(4'd1, 0);
    apply_stimulus(4'd2, 0);
    apply_stimulus(4'd11, 0);
`ifdef KEYPAD_BACKSPACE_EN
    check_output("bs_p0", int'(p0), 1);
    check_output("bs_p1", int'(p1), 0);
    check_output("bs_digit_cnt", int'(digit_cnt), 1);
`else
    check_output("bs_p0", int'(p0), 2);
    check_output("bs_p1", int'(p1), 1);
    check_output("bs_digit_cnt", int'(digit_cnt), 2);
`endif

    $display("[TB] reset during debounce");
    start    = pulses_seen;
    key      = 4'd5;
    key_down = 1'b1;
    t        = 0;
    while (rows == 4'hF && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_output("mid_rst_row_driven", int'(rows != 4'hF), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    m_pval = 0;
    m_cnt  = 0;
    repeat (3) @(negedge clk);
    key_down = 1'b0;
    rst      = 1'b0;
    repeat (40) @(negedge clk);
    check_output("mid_rst_no_pulse", pulses_seen, start);
    check_output("mid_rst_cnt", int'(digit_cnt), 0);

    $display("[TB] random presses");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 15) < 10) code = 4'($urandom_range(0, 9));
      else                            code = 4'($urandom_range(10, 15));
      apply_stimulus(code, $urandom_range(0, 3));
    end

    repeat (10) @(negedge clk);
    check_output("scoreboard_empty", exp_q.size(), 0);
    check_output("pulse_count", pulses_seen, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart of the safe-box 7-segment password display. Scans a 4x4 matrix keypad, debounces and decodes presses, and assembles a 4-digit password in the nibble registers `p0..p3` that feed the display driver and the password comparator. It also drives the display's digits/dash select and pulses `entry_done` or `entry_err` when the user presses Enter.

## Interface
- `SCAN_DIV`, 50000: clk cycles per scan tick (1 kHz at 50 MHz); must be ≥ 2.
- `DEBOUNCE_TICKS`, 4: consecutive ticks a level must persist to count as a press or release; range 1..15.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `rows`  in  4  keypad row inputs, active-low, externally pulled up; asynchronous.
- `cols`  out  4  column drive, one-hot-low.
- `key_valid`  out  1  one-cycle pulse per debounced press.
- `key_code`  out  4  `{row[1:0], col[1:0]}` of the last press; held between pulses.
- `p0`, `p1`, `p2`, `p3`  out  4 each  entered digits; `p0` is the most recent.
- `digit_cnt`  out  3  number of digits entered, 0..4.
- `show_digits`  out  1  high when `digit_cnt` != 0; feeds the display's digits/dash select.
- `entry_done`  out  1  one-cycle pulse: a 4-digit entry was submitted.
- `entry_err`  out  1  one-cycle pulse: Enter was pressed with fewer than 4 digits.

## Operation
- `rows` pass through a 2-flop synchronizer before use.
- Scan tick: a one-cycle strobe when the free-running divider reaches `SCAN_DIV-1`. The divider then wraps to 0.
- `cols` drives the active column `col` low (`cols = ~(4'b1 << col)`). `col` advances 0→1→2→3→0 only in SCAN, on a tick where no key is detected.

FSM, evaluated on scan ticks only:
- **SCAN**: if any synchronized row is low, latch `row` (lowest index wins), freeze `col`, set `cnt=1` and go to DEBOUNCE. Otherwise advance `col`.
- **DEBOUNCE**: latched row still low → `cnt++`. When `cnt` reaches `DEBOUNCE_TICKS`, pulse `key_valid`, load `key_code`, set `cnt=0` and go to HELD. Latched row high → go to SCAN and advance `col`, with no pulse.
- **HELD**: latched row high → `cnt++`; latched row low → `cnt=0`. When `cnt` reaches `DEBOUNCE_TICKS`, go to SCAN and advance `col`.
- With `DEBOUNCE_TICKS=1`, the press is accepted on the tick after detection.
- While a key is held, other columns are not scanned, so a second key in another column is ignored until release. A second key in the same column is ignored because only the latched row is watched.

Entry buffer, acting on `key_valid`:
- Digit keys are codes 0–9.
  - `digit_cnt < 4`: shift `p3←p2`, `p2←p1`, `p1←p0`, `p0←key_code`, then `digit_cnt++`.
  - `digit_cnt == 4`: the key is ignored.
- Code 10 (Clear): all `p*` = 0, `digit_cnt` = 0.
- Code 14 (Enter):
  - `digit_cnt == 4`: pulse `entry_done`; `p*` stay unchanged; `digit_cnt` = 0.
  - Otherwise: pulse `entry_err`; `p*` = 0; `digit_cnt` = 0.
- After Enter, the first new digit shifts into the stale `p*` values. The comparator must sample `p*` on `entry_done`.
- Codes 11, 12, 13 and 15 are ignored, except as given under Configuration.

## Timing
- Reset values: `cols = 4'b1110` (`col` 0), FSM in SCAN, divider 0, `cnt` 0. `key_valid`, `key_code`, `p0..p3`, `digit_cnt`, `show_digits`, `entry_done` and `entry_err` are all 0.
- `key_valid` rises in the clk cycle after the accepting tick.
- `p*`, `digit_cnt`, `show_digits`, `entry_done` and `entry_err` update in the cycle after `key_valid`. The two pulses last exactly one cycle.
- Press latency, from `rows` stable low to `key_valid`: at most (4 + `DEBOUNCE_TICKS`) × `SCAN_DIV` + 3 clk.
- The earliest next press is `DEBOUNCE_TICKS` ticks after release begins.
- Reset asserted mid-operation: every register returns to its reset value immediately. No pulse is emitted during or on exit from reset.
- `entry_done` and `entry_err` are never high in the same cycle.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined: code 11 is Backspace.
  - `digit_cnt > 0`: shift `p0←p1`, `p1←p2`, `p2←p3`, `p3←0`, then `digit_cnt--`.
  - `digit_cnt == 0`: no effect.
- Not defined: code 11 is ignored, and no backspace logic is synthesized.

## Test plan
All scenarios use `SCAN_DIV=4`, `DEBOUNCE_TICKS=2`.
- Reset, then idle for 40 clk → `cols` cycles 1110, 1101, 1011, 0111 every 4 clk; no `key_valid`.
- Hold row 1 low while `cols=1011` (key 6) for 3 ticks → `key_valid` pulses once with `key_code=6`; `p0=6`, `digit_cnt=1`, `show_digits=1`; no second pulse while held.
- Row low for only 1 tick, then high → no `key_valid`; scanning resumes.
- Enter 1, 2, 3, 4, 5, then Enter (code 14) → `p3..p0 = 1,2,3,4` (the 5 is ignored); one-cycle `entry_done`; `digit_cnt=0`; `p*` unchanged.
- Enter 7, 8, then Enter → one-cycle `entry_err`; all `p*=0`; `digit_cnt=0`.
- Backspace:
  - With `KEYPAD_BACKSPACE_EN`: enter 1, 2, then code 11 → `p0=1`, `p1=0`, `digit_cnt=1`.
  - Without the macro: same input → `p0=2`, `p1=1`, `digit_cnt=2`.
  - Assert `rst` mid-debounce → all outputs return to their reset values.
